// File: rtl/id_hazard_ctl.sv
// rtl/id_hazard_ctl.sv - load-use / branch-flush / mem-wait hazard controller
module id_hazard_ctl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic [2:0]       EX_ctlm,
  input  logic [4:0]       EX_rt,
  input  logic             MEM_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Counter holds the flush cycles still owed after the branch cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     r_ret_state;
  logic [2:0] r_flush_left;

  state_t     w_next_state;
  state_t     w_next_ret;
  logic [2:0] w_next_left;
  state_t     w_eff_state;
  logic       w_load_use;
  logic       w_flushing;
  logic       w_unused_ctlm;

  // Only memread matters here; the other MEM control bits are ignored.
  assign w_unused_ctlm = EX_ctlm[2] ^ EX_ctlm[0];

  // $zero is never a real producer, so it can never cause a stall.
  assign w_load_use = EX_ctlm[1] & (EX_rt != 5'd0) &
                      ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)));

  // Once memory is ready again, MEM_WAIT acts as the state it interrupted,
  // so a suspended flush resumes on that very cycle.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;
  assign w_flushing  = MEM_branch_taken | (w_eff_state == FLUSH);

  // State register, saved return state and flush down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_ret_state  <= RUN;
      r_flush_left <= 3'd0;
    end else begin
      r_state      <= w_next_state;
      r_ret_state  <= w_next_ret;
      r_flush_left <= w_next_left;
    end
  end

  // Next-state logic: a busy memory overrides everything and parks the FSM.
  always_comb begin
    w_next_state = r_state;
    w_next_ret   = r_ret_state;
    w_next_left  = r_flush_left;
    if (mem_busy) begin
      // A branch seen while busy is dropped; MEM re-presents it later.
      w_next_state = MEM_WAIT;
      w_next_ret   = w_eff_state;
    end else if (MEM_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        w_next_state = FLUSH;
        w_next_left  = FLUSH_RELOAD;
      end else begin
        w_next_state = RUN;
        w_next_left  = 3'd0;
      end
    end else if (w_eff_state == FLUSH) begin
      if (r_flush_left <= 3'd1) begin
        w_next_state = RUN;
        w_next_left  = 3'd0;
      end else begin
        w_next_state = FLUSH;
        w_next_left  = r_flush_left - 3'd1;
      end
    end else begin
      w_next_state = RUN;
    end
  end

  // Output decode is zero-latency so the enables gate the coming edge;
  // reset forces the idle values even if hazard inputs are active.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_en = 1'b1;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
    end else if (w_flushing) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctl.sv
// tb/tb_id_hazard_ctl.sv - directed scoreboard bench for id_hazard_ctl
module tb_id_hazard_ctl;

  // Output bundle order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_uses_rt, MEM_branch_taken, mem_busy;
  logic [2:0]  EX_ctlm;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_freeze;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  typedef struct {
    string       tag;
    logic [4:0]  outs;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_stall  = 16'd0;
  logic [15:0] m_flush  = 16'd0;

  always #5 clk = ~clk;

  id_hazard_ctl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_ctlm(EX_ctlm), .EX_rt(EX_rt), .MEM_branch_taken(MEM_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_hazard_ctl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_ctlm(EX_ctlm), .EX_rt(EX_rt), .MEM_branch_taken(MEM_branch_taken),
    .mem_busy(mem_busy), .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .pipe_freeze(s_pipe_freeze),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic check_front();
    exp_t       e;
    logic [4:0] got;
    e   = exp_q.pop_front();
    got = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze};
    checks++;
    assert (got === e.outs) else begin
      failures++;
      $error("FAIL %s outs got=%b want=%b", e.tag, got, e.outs);
    end
    checks++;
    assert ({stall_cnt, flush_cnt} === {e.sc, e.fc}) else begin
      failures++;
      $error("FAIL %s cnt got stall=%0d flush=%0d want stall=%0d flush=%0d",
             e.tag, stall_cnt, flush_cnt, e.sc, e.fc);
    end
  endtask

  task automatic push_exp(input string tag, input logic [4:0] outs);
    exp_t e;
    e.tag  = tag;
    e.outs = outs;
    e.sc   = m_stall;
    e.fc   = m_flush;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs after the edge, check before the next edge,
  // then account the counters that edge will bump.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic [2:0] ctlm, input logic [4:0] ert,
                      input logic br, input logic busy, input logic [4:0] outs);
    @(posedge clk);
    #1;
    ID_rs = rs; ID_rt = rt; ID_uses_rt = uses; EX_ctlm = ctlm; EX_rt = ert;
    MEM_branch_taken = br; mem_busy = busy;
    push_exp(tag, outs);
    #3;
    check_front();
    if (!outs[4]) m_stall = m_stall + 16'd1;
    if (outs[2])  m_flush = m_flush + 16'd1;
  endtask

  task automatic idle(input string tag, input logic [4:0] outs);
    step(tag, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, outs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hazards active: outputs must still show idle values.
    rst_n = 1'b0;
    ID_rs = 5'd5; ID_rt = 5'd0; ID_uses_rt = 1'b0; EX_ctlm = 3'b010; EX_rt = 5'd5;
    MEM_branch_taken = 1'b1; mem_busy = 1'b1;
    #2;
    push_exp("reset", O_RUN);
    check_front();
    checks++;
    assert (s_stall_cnt === 4'd0) else begin
      failures++;
      $error("FAIL reset_small got=%0d want=0", s_stall_cnt);
    end
    ID_rs = 5'd0; EX_ctlm = 3'b000; EX_rt = 5'd0; MEM_branch_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    idle("idle", O_RUN);

    // Load-use on rs, then the bubble clears it.
    step("lu_rs",   5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b0, 1'b0, O_STALL);
    idle("lu_rs_after", O_RUN);

    // rt only matters when the ID instruction reads it; $zero never stalls.
    step("lu_rt_unused", 5'd0, 5'd7, 1'b0, 3'b010, 5'd7, 1'b0, 1'b0, O_RUN);
    step("lu_rt_used",   5'd0, 5'd7, 1'b1, 3'b010, 5'd7, 1'b0, 1'b0, O_STALL);
    step("lu_zero",      5'd0, 5'd0, 1'b1, 3'b010, 5'd0, 1'b0, 1'b0, O_RUN);
    step("no_memread",   5'd9, 5'd0, 1'b0, 3'b101, 5'd9, 1'b0, 1'b0, O_RUN);

    // Branch pulse gives exactly three flush cycles.
    step("br_1", 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0, O_FLUSH);
    idle("br_2", O_FLUSH);
    idle("br_3", O_FLUSH);
    idle("br_done", O_RUN);

    // Memory wait on flush cycle 2 suspends the flush, which then finishes.
    step("bw_1", 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0, O_FLUSH);
    for (int i = 0; i < 4; i++) begin
      step("bw_busy", 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, O_FREEZE);
    end
    idle("bw_2", O_FLUSH);
    idle("bw_3", O_FLUSH);
    idle("bw_done", O_RUN);

    // Everything at once: freeze wins, then flush beats load-use.
    step("coll_busy", 5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b1, O_FREEZE);
    step("coll_br",   5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b0, O_FLUSH);
    idle("coll_f2", O_FLUSH);
    idle("coll_f3", O_FLUSH);
    idle("coll_done", O_RUN);

    // Asynchronous reset in the middle of a flush.
    step("rst_br", 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0, O_FLUSH);
    idle("rst_f2", O_FLUSH);
    rst_n = 1'b0;
    m_stall = 16'd0;
    m_flush = 16'd0;
    #1;
    push_exp("rst_async", O_RUN);
    check_front();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("rst_after", O_RUN);

    // Twenty stall cycles: wide counter counts, narrow one saturates.
    for (int i = 0; i < 20; i++) begin
      step("sat_stall", 5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b0, 1'b0, O_STALL);
    end
    idle("sat_end", O_RUN);
    checks++;
    assert (s_stall_cnt === 4'd15) else begin
      failures++;
      $error("FAIL sat_small got=%0d want=15", s_stall_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctl.md
Name: id_hazard_ctl

Overview:
- Hazard and stall controller that drives the write side of the ID/EX pipeline register and the IF/ID/PC enables.
- Watches the EX-stage fields coming out of ID/EX (EX_ctlm, EX_rt) and the ID-stage source registers, and issues:
  - load-use stalls,
  - bubbles into ID/EX,
  - branch flushes,
  - memory-wait freezes.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID flush and ID/EX bubble are held after a taken branch (1..7).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_uses_rt  input  1  instruction in ID reads rt as a source.
- EX_ctlm  input  3  MEM control bits of the instruction in EX; bit1 = memread.
- EX_rt  input  5  destination rt of the instruction in EX.
- MEM_branch_taken  input  1  branch resolved taken in MEM this cycle.
- mem_busy  input  1  data memory not ready; whole pipe must freeze.
- pc_en  output  1  PC write enable.
- ifid_en  output  1  IF/ID write enable.
- ifid_flush  output  1  zero IF/ID on next edge.
- idex_bubble  output  1  force ID_ctlwb/ID_ctlm/ID_ctlex to 0 on next ID/EX capture.
- pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB (mem wait).
- stall_cnt  output  CNT_W  saturating count of load-use + mem-wait cycles.
- flush_cnt  output  CNT_W  saturating count of flush cycles.

Behaviour:
- FSM states: RUN, FLUSH, MEM_WAIT.
- Reset (rst_n low, async):
  - state = RUN, flush counter = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs during reset: pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_bubble = 0, pipe_freeze = 0.
- load_use (combinational) = EX_ctlm[1] & (EX_rt != 0) & ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt))).
- Priority each cycle, highest first: mem_busy > MEM_branch_taken / FLUSH state > load_use > normal.
- Output decode (combinational from state + inputs, zero latency; the enables must gate the same edge):
  - mem_busy = 1 (any state): pipe_freeze = 1, pc_en = 0, ifid_en = 0, ifid_flush = 0, idex_bubble = 0.
  - else MEM_branch_taken = 1 or state = FLUSH: ifid_flush = 1, idex_bubble = 1, pc_en = 1, ifid_en = 1.
  - else load_use: pc_en = 0, ifid_en = 0, idex_bubble = 1. This is a 1-cycle stall; next cycle EX holds a bubble, so load_use clears naturally.
  - else all enables = 1, all other outputs = 0.
- Transitions:
  - RUN -> MEM_WAIT on mem_busy.
  - RUN -> FLUSH on MEM_branch_taken with FLUSH_CYCLES > 1; load the down-counter with FLUSH_CYCLES - 1.
  - FLUSH decrements its counter each non-busy cycle. Returns to RUN when the counter reaches 0 with the last flush cycle asserted.
  - A new MEM_branch_taken in FLUSH reloads the counter.
  - MEM_WAIT -> previous state (RUN, or FLUSH with its counter preserved) on the first cycle mem_busy = 0. A MEM_branch_taken arriving while busy is ignored (MEM holds it and re-presents it).
  - Any state -> RUN asynchronously on reset, including mid-flush or mid-wait.
- Counters:
  - stall_cnt +1 on each edge where pc_en = 0.
  - flush_cnt +1 on each edge where ifid_flush = 1.
  - Both saturate at all-ones; no wrap.
- Register $zero (EX_rt = 0) never triggers a stall.

Test Plan:
- Load-use on rs: EX_ctlm = 3'b010, EX_rt = 5, ID_rs = 5 for 1 cycle -> pc_en = 0, ifid_en = 0, idex_bubble = 1 that cycle; stall_cnt 0 -> 1; next cycle (EX_ctlm = 0) all enables 1.
- Load-use rt gating: EX_rt = 7, ID_rt = 7: with ID_uses_rt = 0 -> no stall; with ID_uses_rt = 1 -> stall. EX_rt = 0 = ID_rs -> no stall.
- Branch flush, FLUSH_CYCLES = 3: MEM_branch_taken pulse 1 cycle -> ifid_flush = idex_bubble = 1 for exactly 3 cycles; flush_cnt = 3; state back to RUN.
- Mem wait during flush: branch pulse (FLUSH_CYCLES = 3), then mem_busy = 1 for 4 cycles on flush cycle 2 -> pipe_freeze = 1 and flush suppressed for 4 cycles; flush then resumes for 2 more cycles; flush_cnt = 3, stall_cnt = 4.
- Priority collision: load_use, MEM_branch_taken and mem_busy all 1 -> only freeze outputs; drop mem_busy while keeping the other two -> flush outputs, pc_en = 1.
- Reset mid-operation and saturation:
  - rst_n low during FLUSH -> outputs return to reset values immediately, without waiting for a clock edge.
  - With CNT_W = 4 and 20 stall cycles -> stall_cnt holds at 15.
